// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
// Optional build macro used by the fetch unit: FETCH_MISALIGN_TRAP_EN.
package otter_fetch_pkg;

   // Canonical RISC-V NOP (addi x0, x0, 0), also used as the filler word
   localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   // One buffered fetch result: the PC it was fetched from, the word, and
   // whether it is a misaligned-fetch marker rather than a real instruction
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_entry_t;

   // Clear the byte offset so the address names a whole instruction word
   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/otter_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched instructions for decode.
// Clear has priority over push/pop; a push in the clear cycle lands in an
// otherwise empty buffer so a marker can be installed during a flush.
module fetch_buffer
   import otter_fetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_VEC,
   localparam int         CW       = $clog2(DEPTH + 1),
   localparam int         PW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          clear,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_pop;

   // Next-state pointers, occupancy and storage for push/pop/clear
   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      do_pop   = pop && (count_q != '0);
      if (clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         if (push) begin
            mem_d[0] = push_entry;
            wr_ptr_d = PW'(1);
            count_d  = CW'(1);
         end
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(do_pop);
      end
   end

   // Register the FIFO state; entries reset to a NOP at the reset PC so the
   // head outputs are well defined straight out of reset
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i].pc       <= RESET_PC;
            mem_q[i].instr    <= NOP_INSTR;
            mem_q[i].misalign <= 1'b0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER instruction-fetch stage: owns the fetch PC, issues in-order word
// requests to instruction memory under a credit limit, buffers responses
// with their PCs and discards responses that were in flight at a redirect.
// Optional build macro: FETCH_MISALIGN_TRAP_EN turns a misaligned redirect
// into a sticky marker entry instead of silently aligning the target.
module otter_fetch_unit
   import otter_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_VEC       = DEFAULT_RESET_VEC,
   parameter int          BUF_DEPTH       = 2,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REDIRECT_VALID,
   input  logic [31:0] REDIRECT_PC,
   output logic        IMEM_REQ_VALID,
   input  logic        IMEM_REQ_READY,
   output logic [31:0] IMEM_ADDR,
   input  logic        IMEM_RSP_VALID,
   input  logic [31:0] IMEM_RSP_DATA,
   output logic        IF_VALID,
   input  logic        IF_READY,
   output logic [31:0] IF_PC,
   output logic [31:0] IF_INSTR,
   output logic        IF_MISALIGN
);

   localparam int IW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  rsp_pc_q, rsp_pc_d;
   logic [IW-1:0] inflight_q, inflight_d;
   logic [IW-1:0] discard_q, discard_d;
   logic         halt_q, halt_d;

   logic         redirect_misaligned;
   logic         req_valid;
   logic         req_fire;
   logic         buf_push;
   logic         buf_pop;
   logic         buf_clear;
   fetch_entry_t push_entry;
   fetch_entry_t head;
   logic [CW-1:0] buf_count;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign redirect_misaligned = REDIRECT_VALID && (REDIRECT_PC[1:0] != 2'b00);
`else
   assign redirect_misaligned = 1'b0;
`endif

   // Issue only when both the memory credit and the buffer space reserved
   // for every outstanding response allow it, so responses never back up
   always_comb begin
      req_valid = !RST && !REDIRECT_VALID && !halt_q
                  && (int'(inflight_q) < MAX_OUTSTANDING)
                  && ((int'(inflight_q) + int'(buf_count)) < BUF_DEPTH);
      req_fire  = req_valid && IMEM_REQ_READY;
   end

   assign IMEM_REQ_VALID = req_valid;
   assign IMEM_ADDR      = fetch_pc_q;

   // PC, credit and discard bookkeeping; a redirect overrides everything and
   // turns every still-outstanding response into one to be dropped
   always_comb begin
      fetch_pc_d          = fetch_pc_q;
      rsp_pc_d            = rsp_pc_q;
      discard_d           = discard_q;
      halt_d              = halt_q;
      buf_push            = 1'b0;
      buf_clear           = 1'b0;
      push_entry.pc       = rsp_pc_q;
      push_entry.instr    = IMEM_RSP_DATA;
      push_entry.misalign = 1'b0;
      inflight_d          = inflight_q + IW'(req_fire) - IW'(IMEM_RSP_VALID);
      if (REDIRECT_VALID) begin
         fetch_pc_d = align_word(REDIRECT_PC);
         rsp_pc_d   = align_word(REDIRECT_PC);
         buf_clear  = 1'b1;
         discard_d  = inflight_q - IW'(IMEM_RSP_VALID);
         halt_d     = redirect_misaligned;
         if (redirect_misaligned) begin
            buf_push            = 1'b1;
            push_entry.pc       = REDIRECT_PC;
            push_entry.instr    = NOP_INSTR;
            push_entry.misalign = 1'b1;
         end
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (IMEM_RSP_VALID) begin
            if (discard_q != '0) begin
               discard_d = discard_q - 1'b1;
            end else begin
               buf_push = 1'b1;
               rsp_pc_d = rsp_pc_q + 32'd4;
            end
         end
      end
   end

   // Fetch-control state registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc_q <= RESET_VEC;
         rsp_pc_q   <= RESET_VEC;
         inflight_q <= '0;
         discard_q  <= '0;
         halt_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         halt_q     <= halt_d;
      end
   end

   // A marker at the head is sticky: decode cannot consume it, only a
   // subsequent redirect removes it
   always_comb begin
      buf_pop = IF_VALID && IF_READY && !head.misalign;
   end

   fetch_buffer #(
      .DEPTH    (BUF_DEPTH),
      .RESET_PC (RESET_VEC)
   ) u_fetch_buffer (
      .clk        (CLK),
      .rst        (RST),
      .push       (buf_push),
      .push_entry (push_entry),
      .pop        (buf_pop),
      .clear      (buf_clear),
      .count      (buf_count),
      .head       (head)
   );

   assign IF_VALID = (buf_count != '0);
   assign IF_PC    = head.pc;
   assign IF_INSTR = head.instr;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign IF_MISALIGN = head.misalign;
`else
   assign IF_MISALIGN = 1'b0;
`endif

   // Flag handshake or credit violations that the issue rule should prevent
   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!(IMEM_RSP_VALID && (inflight_q == '0)));
         assert (!(req_fire && !IMEM_RSP_VALID
                   && (int'(inflight_q) == MAX_OUTSTANDING)));
         assert (!(buf_push && !buf_clear && !buf_pop
                   && (int'(buf_count) == BUF_DEPTH)));
      end
   end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// Directed scoreboard bench for otter_fetch_unit. A small memory model
// answers each accepted request one cycle later (or later when stalled);
// accepted addresses are pushed to a scoreboard and checked in order as
// decode consumes them. Honours FETCH_MISALIGN_TRAP_EN when defined.
module tb_otter_fetch_unit;
   import otter_fetch_pkg::*;

   localparam logic [31:0] RV = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] imem_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_misalign;

   logic [31:0] mem_q [$];
   logic [31:0] sb_q [$];
   logic        rsp_en;
   logic        marker_mode;
   logic [31:0] exp_next_addr;
   int          tests_run;
   int          fails;
   int          accepts;
   int          delivered;

   logic        obs_req_valid, obs_if_valid, obs_if_misalign;
   logic [31:0] obs_addr, obs_if_pc, obs_if_instr;
   logic        popped, acc_flag;
   logic [31:0] popped_pc, acc_addr;

   otter_fetch_unit #(
      .RESET_VEC       (RV),
      .BUF_DEPTH       (2),
      .MAX_OUTSTANDING (2)
   ) dut (
      .CLK            (clk),
      .RST            (rst),
      .REDIRECT_VALID (redirect_valid),
      .REDIRECT_PC    (redirect_pc),
      .IMEM_REQ_VALID (req_valid),
      .IMEM_REQ_READY (req_ready),
      .IMEM_ADDR      (imem_addr),
      .IMEM_RSP_VALID (rsp_valid),
      .IMEM_RSP_DATA  (rsp_data),
      .IF_VALID       (if_valid),
      .IF_READY       (if_ready),
      .IF_PC          (if_pc),
      .IF_INSTR       (if_instr),
      .IF_MISALIGN    (if_misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word the memory model returns for a given address
   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return {a[31:2] ^ 30'h2AAA_5555, 2'b11};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock: drive the memory response at negedge, sample, update models
   task automatic applyStimulus();
      logic [31:0] a;
      logic [31:0] exp_pc;
      @(negedge clk);
      if (!rst && rsp_en && mem_q.size() != 0) begin
         a         = mem_q.pop_front();
         rsp_valid = 1'b1;
         rsp_data  = instr_of(a);
      end else begin
         rsp_valid = 1'b0;
         rsp_data  = '0;
      end
      #1;
      obs_req_valid   = req_valid;
      obs_addr        = imem_addr;
      obs_if_valid    = if_valid;
      obs_if_pc       = if_pc;
      obs_if_instr    = if_instr;
      obs_if_misalign = if_misalign;
      popped          = 1'b0;
      acc_flag        = 1'b0;
      if (rst) begin
         mem_q.delete();
         sb_q.delete();
         exp_next_addr = RV;
         marker_mode   = 1'b0;
      end else begin
         if (obs_if_valid && if_ready && !marker_mode) begin
            exp_pc = (sb_q.size() != 0) ? sb_q[0] : 32'hxxxx_xxxx;
            checkOutput("if_pc", obs_if_pc, exp_pc);
            checkOutput("if_instr", obs_if_instr, instr_of(exp_pc));
            checkOutput("if_misalign", {31'b0, obs_if_misalign}, 32'd0);
            if (sb_q.size() != 0) void'(sb_q.pop_front());
            popped    = 1'b1;
            popped_pc = obs_if_pc;
            delivered++;
         end
         if (redirect_valid) begin
            checkOutput("req_in_redirect", {31'b0, obs_req_valid}, 32'd0);
            sb_q.delete();
            exp_next_addr = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
            marker_mode = (redirect_pc[1:0] != 2'b00);
`else
            marker_mode = 1'b0;
`endif
         end else if (obs_req_valid && req_ready) begin
            checkOutput("req_addr", obs_addr, exp_next_addr);
            mem_q.push_back(obs_addr);
            sb_q.push_back(exp_next_addr);
            exp_next_addr = exp_next_addr + 32'd4;
            acc_flag      = 1'b1;
            acc_addr      = obs_addr;
            accepts++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) applyStimulus();
   endtask

   task automatic doReset();
      rst = 1'b1;
      redirect_valid = 1'b0;
      run(2);
      rst = 1'b0;
   endtask

   task automatic doRedirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      applyStimulus();
      redirect_valid = 1'b0;
   endtask

   // Wait (bounded) for the next instruction consumed by decode
   task automatic waitFirstPc(input string tag, input logic [31:0] expv, input int max_cycles);
      logic [31:0] got;
      got = 32'hxxxx_xxxx;
      for (int i = 0; i < max_cycles; i++) begin
         applyStimulus();
         if (popped) begin
            got = popped_pc;
            break;
         end
      end
      checkOutput(tag, got, expv);
   endtask

   // Wait (bounded) for the next accepted memory request
   task automatic waitAccept(input string tag, input logic [31:0] expv, input int max_cycles);
      logic [31:0] got;
      got = 32'hxxxx_xxxx;
      for (int i = 0; i < max_cycles; i++) begin
         applyStimulus();
         if (acc_flag) begin
            got = acc_addr;
            break;
         end
      end
      checkOutput(tag, got, expv);
   endtask

   initial begin
      int base;
      tests_run = 0;
      fails = 0;
      accepts = 0;
      delivered = 0;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      req_ready = 1'b1;
      if_ready = 1'b1;
      rsp_en = 1'b1;
      rsp_valid = 1'b0;
      rsp_data = '0;
      marker_mode = 1'b0;
      exp_next_addr = RV;

      // Reset state
      doReset();
      checkOutput("rst_req_valid", {31'b0, obs_req_valid}, 32'd0);
      checkOutput("rst_if_valid", {31'b0, obs_if_valid}, 32'd0);
      checkOutput("rst_if_pc", obs_if_pc, RV);
      checkOutput("rst_if_instr", obs_if_instr, NOP_INSTR);
      checkOutput("rst_if_misalign", {31'b0, obs_if_misalign}, 32'd0);

      // Steady sequential fetch from the reset vector
      waitAccept("first_req", 32'h0, 4);
      base = delivered;
      run(10);
      checkOutput("progress", {31'b0, (delivered - base) >= 5}, 32'd1);

      // Decode stalls: fetch stops once two instructions are buffered
      if_ready = 1'b0;
      run(6);
      checkOutput("stall_req_valid", {31'b0, obs_req_valid}, 32'd0);
      checkOutput("stall_if_valid", {31'b0, obs_if_valid}, 32'd1);
      checkOutput("stall_buffered", 32'(sb_q.size()), 32'd2);
      checkOutput("stall_inflight", 32'(mem_q.size()), 32'd0);
      if_ready = 1'b1;
      run(8);

      // Mid-operation reset, then memory stalls with address 0x8 pending
      doReset();
      checkOutput("rst2_if_valid", {31'b0, obs_if_valid}, 32'd0);
      base = accepts;
      for (int i = 0; i < 8 && (accepts - base) < 2; i++) applyStimulus();
      checkOutput("two_accepts", 32'(accepts - base), 32'd2);
      req_ready = 1'b0;
      applyStimulus();
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("hold_valid", {31'b0, obs_req_valid}, 32'd1);
         checkOutput("hold_addr", obs_addr, 32'h8);
      end
      req_ready = 1'b1;
      waitAccept("release_addr", 32'h8, 2);
      waitAccept("advance_addr", 32'hC, 6);
      run(4);

      // Two requests in flight at a redirect: both responses are dropped
      doReset();
      doRedirect(32'h10);
      rsp_en = 1'b0;
      run(3);
      checkOutput("blocked_req_valid", {31'b0, obs_req_valid}, 32'd0);
      checkOutput("two_inflight", 32'(mem_q.size()), 32'd2);
      doRedirect(32'h100);
      rsp_en = 1'b1;
      waitFirstPc("redir_first_pc", 32'h100, 12);
      run(4);

      // Redirect in the same cycle a response arrives
      rsp_en = 1'b0;
      run(4);
      checkOutput("two_inflight_b", 32'(mem_q.size()), 32'd2);
      rsp_en = 1'b1;
      doRedirect(32'h200);
      waitFirstPc("redir_rsp_first_pc", 32'h200, 12);
      run(4);

      // PC wraps modulo 2^32
      doRedirect(32'hFFFF_FFF8);
      waitFirstPc("wrap_first_pc", 32'hFFFF_FFF8, 12);
      run(10);

`ifdef FETCH_MISALIGN_TRAP_EN
      // Misaligned redirect yields a sticky marker and halts fetching
      doRedirect(32'h102);
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
         checkOutput("mis_req_valid", {31'b0, obs_req_valid}, 32'd0);
         checkOutput("mis_if_valid", {31'b0, obs_if_valid}, 32'd1);
         checkOutput("mis_flag", {31'b0, obs_if_misalign}, 32'd1);
         checkOutput("mis_pc", obs_if_pc, 32'h102);
         checkOutput("mis_instr", obs_if_instr, NOP_INSTR);
      end
      doRedirect(32'h200);
      waitFirstPc("mis_resume_pc", 32'h200, 12);
`else
      // Without the trap, low target bits are ignored
      doRedirect(32'h102);
      waitFirstPc("mis_ignored_pc", 32'h100, 12);
      checkOutput("mis_flag_off", {31'b0, obs_if_misalign}, 32'd0);
`endif
      run(6);

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   // Hard stop in case the sequence ever stalls
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
